// File: rtl/bfloat_cmp_pkg.sv
// rtl/bfloat_cmp_pkg.sv - shared types and helpers for the BFloat16 compare unit
// Contents: op_e opcode enum, cmp_flags_t per-lane relation flags,
// default field widths and a width-parametrised canonical-NaN builder.
package bfloat_cmp_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 7;

    typedef enum logic [2:0] {
        OP_EQ  = 3'b000,
        OP_LT  = 3'b001,
        OP_LE  = 3'b010,
        OP_GT  = 3'b011,
        OP_GE  = 3'b100,
        OP_MIN = 3'b101,
        OP_MAX = 3'b110,
        OP_CMP = 3'b111
    } op_e;

    typedef struct packed {
        logic unord;
        logic gt;
        logic eq;
        logic lt;
    } cmp_flags_t;

    // Sign 0, exponent all ones, mantissa MSB set: a contiguous run of
    // exp_w+1 ones starting at bit man_w-1. Callers cast to their width.
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        return ((64'd1 << (exp_w + 1)) - 64'd1) << (man_w - 1);
    endfunction

endpackage

// File: rtl/bfloat_cmp_lane.sv
// rtl/bfloat_cmp_lane.sv - combinational single-lane float ordering and result select
// Ports: op (shared opcode), a/b (one W-bit operand each),
//        res (W-bit selected/boolean result), flags ({unord, gt, eq, lt}).
// Optional: BFLOAT_CMP_DAZ_EN treats subnormal operands as signed zero for ordering.
module bfloat_cmp_lane
    import bfloat_cmp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  op_e              op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [W-1:0]     res,
    output cmp_flags_t       flags
);

    localparam logic [W-1:0] CNAN = W'(canon_nan(EXP_W, MAN_W));

    logic             sign_a, sign_b;
    logic             nan_a, nan_b;
    logic             zero_a, zero_b, both_zero;
    logic [W-2:0]     mag_a, mag_b;
    logic             pick_a_min, pick_a_max;

    assign sign_a = a[W-1];
    assign sign_b = b[W-1];
    assign nan_a  = (&a[W-2:MAN_W]) && (|a[MAN_W-1:0]);
    assign nan_b  = (&b[W-2:MAN_W]) && (|b[MAN_W-1:0]);

`ifdef BFLOAT_CMP_DAZ_EN
    assign zero_a = (a[W-2:MAN_W] == '0);
    assign zero_b = (b[W-2:MAN_W] == '0);
`else
    assign zero_a = (a[W-2:0] == '0);
    assign zero_b = (b[W-2:0] == '0);
`endif

    assign both_zero = zero_a && zero_b;
    // Flushed operands must compare as magnitude zero against non-zero values.
    assign mag_a = zero_a ? '0 : a[W-2:0];
    assign mag_b = zero_b ? '0 : b[W-2:0];

    always_comb begin
        flags = '0;
        if (nan_a || nan_b) begin
            flags.unord = 1'b1;
        end else if (both_zero) begin
            flags.eq = 1'b1;
        end else if (sign_a != sign_b) begin
            flags.lt = sign_a;
            flags.gt = sign_b;
        end else if (mag_a == mag_b) begin
            flags.eq = 1'b1;
        end else if ((mag_a < mag_b) ^ sign_a) begin
            // Same sign: negative values order by reversed magnitude.
            flags.lt = 1'b1;
        end else begin
            flags.gt = 1'b1;
        end
    end

    // Equal zeros of opposite sign: min prefers the negative one, max the
    // positive one. Equal non-zero operands return a.
    assign pick_a_min = flags.lt || (flags.eq && (both_zero ? sign_a : 1'b1));
    assign pick_a_max = flags.gt || (flags.eq && (both_zero ? !sign_a : 1'b1));

    always_comb begin
        res = '0;
        unique case (op)
            OP_EQ:  res = {{(W-1){1'b0}}, flags.eq};
            OP_LT:  res = {{(W-1){1'b0}}, flags.lt};
            OP_LE:  res = {{(W-1){1'b0}}, flags.lt | flags.eq};
            OP_GT:  res = {{(W-1){1'b0}}, flags.gt};
            OP_GE:  res = {{(W-1){1'b0}}, flags.gt | flags.eq};
            OP_MIN: begin
                if (nan_a && nan_b)  res = CNAN;
                else if (nan_a)      res = b;
                else if (nan_b)      res = a;
                else                 res = pick_a_min ? a : b;
            end
            OP_MAX: begin
                if (nan_a && nan_b)  res = CNAN;
                else if (nan_a)      res = b;
                else if (nan_b)      res = a;
                else                 res = pick_a_max ? a : b;
            end
            OP_CMP: begin
                // Legacy 2-bit code: eq 00, lt 01, gt or unordered 11.
                if (flags.eq)        res = {{(W-2){1'b0}}, 2'b00};
                else if (flags.lt)   res = {{(W-2){1'b0}}, 2'b01};
                else                 res = {{(W-2){1'b0}}, 2'b11};
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/bfloat_compare_unit.sv
// rtl/bfloat_compare_unit.sv - multi-lane pipelined BFloat16 comparator and min/max unit
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_op/in_a/in_b operand
//        transaction; out_valid/out_ready/out_res/out_flags result, 2-cycle latency.
//        Lane i occupies [i*W +: W] of in_a/in_b/out_res and [i*4 +: 4] of out_flags.
// Optional: BFLOAT_CMP_DAZ_EN (subnormals ordered as signed zero, see bfloat_cmp_lane).
module bfloat_compare_unit
    import bfloat_cmp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    parameter int LANES = 4,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [LANES*W-1:0]   in_a,
    input  logic [LANES*W-1:0]   in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_res,
    output logic [LANES*4-1:0]   out_flags
);

    logic                 s1_valid;
    op_e                  s1_op;
    logic [LANES*W-1:0]   s1_a, s1_b;
    logic                 s2_valid;
    logic [LANES*W-1:0]   s2_res;
    logic [LANES*4-1:0]   s2_flags;
    logic                 s2_free;
    logic [LANES*W-1:0]   lane_res;
    logic [LANES*4-1:0]   lane_flags;

    // S2 can take a new entry when empty or draining this cycle; S1 can take
    // a new entry when empty or moving into S2. Never depends on in_valid.
    assign s2_free  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bfloat_cmp_lane #(
            .EXP_W (EXP_W),
            .MAN_W (MAN_W)
        ) u_lane (
            .op    (s1_op),
            .a     (s1_a[i*W +: W]),
            .b     (s1_b[i*W +: W]),
            .res   (lane_res[i*W +: W]),
            .flags (lane_flags[i*4 +: 4])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_EQ;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_flags <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_op <= op_e'(in_op);
                    s1_a  <= in_a;
                    s1_b  <= in_b;
                end
            end
            if (s2_free) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_res   <= lane_res;
                    s2_flags <= lane_flags;
                end
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_res   = s2_res;
    assign out_flags = s2_flags;

endmodule

// File: tb/tb_bfloat_compare_unit.sv
// tb/tb_bfloat_compare_unit.sv - scoreboard bench for bfloat_compare_unit with real-valued reference model
module tb_bfloat_compare_unit;

    localparam int LANES = 4;
    localparam int W     = 16;

    localparam logic [2:0] T_EQ = 3'd0, T_LT = 3'd1, T_LE = 3'd2, T_GT = 3'd3,
                           T_GE = 3'd4, T_MIN = 3'd5, T_MAX = 3'd6, T_CMP = 3'd7;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_op;
    logic [LANES*W-1:0]   in_a, in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*W-1:0]   out_res;
    logic [LANES*4-1:0]   out_flags;

    bfloat_compare_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_flags (out_flags)
    );

    typedef struct {
        logic [63:0] res;
        logic [15:0] flags;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_err = 0, n_push = 0, n_pop = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    int   low_cnt = 0;
    bit   saw_not_ready = 0;

    logic [15:0] table_vals [17] = '{16'h0000, 16'h8000, 16'h3F80, 16'hBF80, 16'h4000,
                                     16'hC040, 16'h7F80, 16'hFF80, 16'h7FC0, 16'h7FC1,
                                     16'hFFFF, 16'h0001, 16'h8001, 16'h007F, 16'h0080,
                                     16'h7F7F, 16'hFF7F};

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Numeric value of a bf16 pattern; infinities map beyond any finite value.
    function automatic real bf_val(input logic [15:0] x);
        int  e;
        int  m;
        real v;
        e = int'(x[14:7]);
        m = int'(x[6:0]);
`ifdef BFLOAT_CMP_DAZ_EN
        if (e == 0) m = 0;
`endif
        if (e == 255)     v = 1.0e300;
        else if (e == 0)  v = m * (2.0 ** (-133));
        else              v = (1.0 + m / 128.0) * (2.0 ** (e - 127));
        return x[15] ? -v : v;
    endfunction

    function automatic void ref_lane(input logic [2:0] op, input logic [15:0] a,
                                     input logic [15:0] b, output logic [15:0] r,
                                     output logic [3:0] f);
        logic na, nb, un, lt, eq, gt;
        real  ra, rb;
        na = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
        nb = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
        ra = bf_val(a);
        rb = bf_val(b);
        un = na || nb;
        lt = !un && (ra < rb);
        gt = !un && (ra > rb);
        eq = !un && (ra == rb);
        f  = {un, gt, eq, lt};
        case (op)
            T_EQ:  r = {15'd0, eq};
            T_LT:  r = {15'd0, lt};
            T_LE:  r = {15'd0, lt || eq};
            T_GT:  r = {15'd0, gt};
            T_GE:  r = {15'd0, gt || eq};
            T_MIN: begin
                if (na && nb)        r = 16'h7FC0;
                else if (na)         r = b;
                else if (nb)         r = a;
                else if (lt)         r = a;
                else if (gt)         r = b;
                else if (ra == 0.0)  r = a[15] ? a : b;
                else                 r = a;
            end
            T_MAX: begin
                if (na && nb)        r = 16'h7FC0;
                else if (na)         r = b;
                else if (nb)         r = a;
                else if (gt)         r = a;
                else if (lt)         r = b;
                else if (ra == 0.0)  r = a[15] ? b : a;
                else                 r = a;
            end
            default: r = eq ? 16'd0 : (lt ? 16'd1 : 16'd3);
        endcase
    endfunction

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        if ($urandom_range(1, 0) == 0) v = table_vals[$urandom_range(16, 0)];
        else                           v = 16'($urandom);
        return v;
    endfunction

    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int   waited;
        exp_t e;
        logic [15:0] r;
        logic [3:0]  f;
        waited = 0;
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        #1;
        while (!in_ready) begin
            saw_not_ready = 1;
            @(negedge clk);
            #2;
            waited++;
            if (waited > 100) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
                in_valid = 1'b0;
                return;
            end
        end
        for (int i = 0; i < LANES; i++) begin
            ref_lane(op, a[i*16 +: 16], b[i*16 +: 16], r, f);
            e.res[i*16 +: 16] = r;
            e.flags[i*4 +: 4] = f;
        end
        e.acc = cyc;
        e.lat = (rdy_mode == 0);
        sb.push_back(e);
        n_push++;
    endtask

    task automatic send_l0(input logic [2:0] op, input logic [15:0] a0, input logic [15:0] b0);
        logic [63:0] a, b;
        for (int i = 1; i < LANES; i++) begin
            a[i*16 +: 16] = rand_val();
            b[i*16 +: 16] = rand_val();
        end
        a[15:0] = a0;
        b[15:0] = b0;
        send(op, a, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // out_ready driver: 0 = always ready, 1 = random, 2 = low for low_cnt cycles.
    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(2, 0) != 0);
                default: begin
                    if (low_cnt > 0) begin
                        out_ready = 1'b0;
                        low_cnt--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: a result transfers at the next posedge when out_valid && out_ready.
    initial begin
        logic        held;
        logic [63:0] held_res;
        logic [15:0] held_flags;
        exp_t        e;
        held = 0;
        held_res = '0;
        held_flags = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                held = 0;
            end else begin
                if (held) begin
                    chk("hold_valid", {63'd0, out_valid}, 64'd1);
                    chk("hold_res", out_res, held_res);
                    chk("hold_flags", {48'd0, out_flags}, {48'd0, held_flags});
                end
                held = 0;
                if (out_valid && !out_ready) begin
                    held       = 1;
                    held_res   = out_res;
                    held_flags = out_flags;
                end else if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_output: got res=%h with empty scoreboard, required no output", out_res);
                    end else begin
                        e = sb.pop_front();
                        n_pop++;
                        chk("result", out_res, e.res);
                        chk("flags", {48'd0, out_flags}, {48'd0, e.flags});
                        if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd2);
                    end
                end
            end
        end
    end

    initial begin
        int waited;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_res", out_res, 64'd0);
        chk("reset_out_flags", {48'd0, out_flags}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed cases on lane 0, pipeline always drained.
        rdy_mode = 0;
        send_l0(T_LT,  16'h3F80, 16'h4000);
        send_l0(T_CMP, 16'h3F80, 16'h4000);
        send_l0(T_MAX, 16'h3F80, 16'h4000);
        send_l0(T_EQ,  16'h8000, 16'h0000);
        send_l0(T_MIN, 16'h8000, 16'h0000);
        send_l0(T_MAX, 16'h8000, 16'h0000);
        send_l0(T_MIN, 16'h0000, 16'h8000);
        send_l0(T_GE,  16'h7FC1, 16'hC040);
        send_l0(T_MIN, 16'h7FC1, 16'hC040);
        send_l0(T_MAX, 16'h7FC1, 16'hFFC3);
        send_l0(T_CMP, 16'h7FC1, 16'h3F80);
        send_l0(T_EQ,  16'h0001, 16'h8000);
        send_l0(T_GT,  16'hFF80, 16'hFF7F);
        send_l0(T_LE,  16'h7F80, 16'h7F80);
        idle(4);

        // Backpressure: 4 back-to-back with out_ready low for 3 cycles.
        saw_not_ready = 0;
        low_cnt  = 3;
        rdy_mode = 2;
        for (int i = 0; i < 4; i++) send_l0(3'($urandom_range(7, 0)), rand_val(), rand_val());
        idle(6);
        chk("backpressure_in_ready_dropped", {63'd0, saw_not_ready}, 64'd1);

        // Reset with two transactions in flight.
        low_cnt = 100;
        send_l0(T_MAX, 16'h3F80, 16'h4000);
        send_l0(T_MIN, 16'h3F80, 16'h4000);
        idle(2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", {63'd0, out_valid}, 64'd0);
        sb.delete();
        n_push = n_pop;
        repeat (2) @(negedge clk);
        #2;
        rst_n    = 1'b1;
        low_cnt  = 0;
        rdy_mode = 0;
        idle(8);
        chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);

        // Randomised traffic with random backpressure and input gaps.
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            logic [63:0] a, b;
            if ($urandom_range(3, 0) == 0) begin
                idle(1);
            end else begin
                for (int l = 0; l < LANES; l++) begin
                    a[l*16 +: 16] = rand_val();
                    case ($urandom_range(3, 0))
                        0:       b[l*16 +: 16] = a[l*16 +: 16];
                        1:       b[l*16 +: 16] = a[l*16 +: 16] ^ 16'h8000;
                        default: b[l*16 +: 16] = rand_val();
                    endcase
                end
                send(3'($urandom_range(7, 0)), a, b);
            end
        end
        idle(1);
        rdy_mode = 0;
        waited = 0;
        while (sb.size() != 0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        idle(3);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("push_pop_count", 64'(n_pop), 64'(n_push));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bfloat_compare_unit.md
Name: bfloat_compare_unit

Overview:
- Multi-lane, pipelined BFloat16 comparator and min/max unit; generalised successor of the single-lane 2-bit-code comparator.
- Accepts LANES operand pairs per transaction through a valid/ready handshake.
- Applies one opcode to all lanes and returns per-lane results plus relation flags after a fixed 2-cycle latency.
- Sits between the operand register file and the vector ALU writeback path.

Parameters:
- EXP_W, 8, exponent field width; format width W = 1 + EXP_W + MAN_W.
- MAN_W, 7, mantissa field width.
- LANES, 4, number of independent compare lanes per transaction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  unit can accept a transaction this cycle.
- in_op  in  3  opcode, shared by all lanes.
- in_a  in  LANES*W  operand A; lane i occupies bits [i*W +: W].
- in_b  in  LANES*W  operand B, same packing as in_a.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_res  out  LANES*W  per-lane result.
- out_flags  out  LANES*4  per-lane flags {unord, gt, eq, lt}.

Behaviour:
- Reset: all pipeline valid bits are 0, and out_valid, out_res and out_flags are 0. in_ready is 1 from the first cycle after rst_n deasserts.
- Reset is asynchronous. Asserting it mid-operation discards all in-flight transactions, and no output is produced for them.
- Pipeline: S1 registers op, a and b on acceptance. S2 registers the computed result. A transaction accepted in cycle N appears on out_valid in cycle N+2 if not stalled.
- Handshake:
  - A transfer occurs when valid && ready.
  - An output held with out_valid=1 and out_ready=0 keeps out_res and out_flags stable until accepted.
  - in_ready = !s1_valid || (!s2_valid || out_ready). This gives full throughput of 1 transaction per cycle with no bubbles.
  - in_ready must not depend combinationally on in_valid.
- Ordering per lane (sign-magnitude):
  - +0 == -0.
  - NaN (exp all ones, mantissa != 0) is unordered. It sets unord=1 and lt=eq=gt=0.
  - Infinities order normally.
  - Negative operands compare with reversed magnitude.
  - Exactly one of {lt, eq, gt, unord} is 1 per lane.
- Opcodes; boolean results are W'(1) or W'(0):
  - 000 EQ
  - 001 LT
  - 010 LE
  - 011 GT
  - 100 GE
  - 101 MIN
  - 110 MAX
  - 111 CMP: legacy code in bits [1:0] with upper bits 0: eq -> 2'b00, lt -> 2'b01, gt or unord -> 2'b11.
- Unordered lanes give 0 for every boolean op.
- MIN/MAX:
  - If exactly one operand is NaN, return the other operand.
  - If both are NaN, return canonical NaN: sign 0, exponent all ones, mantissa MSB 1 (0x7FC0 at defaults).
  - min(+0,-0) returns -0; max(+0,-0) returns +0.
  - On equal non-zero operands, return A.
- Lanes are fully independent, and flags are computed for every opcode.

Optional Feature:
- Macro: BFLOAT_CMP_DAZ_EN.
- Defined: any operand with exponent 0 and mantissa != 0 is treated as signed zero for ordering. MIN/MAX then returns the original operand bits of the selected lane.
- Undefined: subnormals are compared exactly by magnitude.

Decomposition:
- Package bfloat_cmp_pkg holds:
  - op_e enum for the 8 opcodes.
  - cmp_flags_t packed struct {unord, gt, eq, lt}.
  - Default EXP_W/MAN_W localparams.
  - Canonical-NaN function parametrised by width.
- Sub-module bfloat_cmp_lane: purely combinational single-lane ordering plus result select, instantiated LANES times by generate.
- Pipeline registers and handshake stay in the top module.

Test Plan:
- Lane0 a=0x3F80 (1.0), b=0x4000 (2.0): op LT -> out_res 0x0001, flags lt; op CMP -> 0x0001; op MAX -> 0x4000. Result appears 2 cycles after acceptance.
- a=0x8000 (-0), b=0x0000: op EQ -> 0x0001, flags eq; op MIN -> 0x8000; op MAX -> 0x0000.
- a=0x7FC1 (NaN), b=0xC040 (-3.0): op GE -> 0x0000, flags unord; op MIN -> 0xC040; both NaN with op MAX -> 0x7FC0.
- Backpressure: stream 4 back-to-back transactions with out_ready held low for 3 cycles -> in_ready drops once both stages are full, output holds stable, and all 4 results emerge in order with none lost or duplicated.
- Assert rst_n low with 2 transactions in flight -> out_valid=0 immediately; after release, no stale result appears and in_ready=1.
- DAZ: a=0x0001, b=0x8000, op EQ -> 0x0001 with BFLOAT_CMP_DAZ_EN defined; 0x0000 with gt flag when undefined.
